// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
//   Shared types for the RV32I 5-stage pipeline hazard controller.
//   - pipe_ctrl_struct : per-stage pipeline-register load enables (19 bits).
//     The IF/ID fields sit in the two MSBs. A load-use stall therefore reads
//     as 19'h1FFFF.
//   - hazard_state_t   : controller FSM state (RUN / MEM_STALL).
//   - hazard_cause_t   : the cause selected by the priority decode this cycle.
//   - helpers          : whole-struct fill and load-use detection.
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

  typedef struct packed {
    logic ifid_pcreg_ld;
    logic ifid_ireg_ld;
    logic idex_pcreg_ld;
    logic idex_ireg_ld;
    logic idex_rs1v_ld;
    logic idex_rs2v_ld;
    logic idex_imm_ld;
    logic idex_ctrl_ld;
    logic exmem_pcreg_ld;
    logic exmem_ireg_ld;
    logic exmem_alu_ld;
    logic exmem_rs2v_ld;
    logic exmem_br_ld;
    logic exmem_ctrl_ld;
    logic memwb_pcreg_ld;
    logic memwb_ireg_ld;
    logic memwb_alu_ld;
    logic memwb_mdr_ld;
    logic memwb_ctrl_ld;
  } pipe_ctrl_struct;

  localparam int PIPE_CTRL_W = $bits(pipe_ctrl_struct);

  typedef enum logic [0:0] {
    RUN       = 1'b0,
    MEM_STALL = 1'b1
  } hazard_state_t;

  typedef enum logic [1:0] {
    HZ_NONE    = 2'd0,
    HZ_MEM     = 2'd1,
    HZ_BRANCH  = 2'd2,
    HZ_LOADUSE = 2'd3
  } hazard_cause_t;

  // Every load enable set to the same value.
  function automatic pipe_ctrl_struct ctrl_fill(input logic v);
    return pipe_ctrl_struct'({PIPE_CTRL_W{v}});
  endfunction

  // A load in ID/EX whose destination is read by the IF/ID instruction.
  // x0 is never a real dependency.
  function automatic logic load_use(input logic       is_load,
                                    input logic [4:0] rd,
                                    input logic [4:0] rs1,
                                    input logic [4:0] rs2,
                                    input logic       uses_rs1,
                                    input logic       uses_rs2);
    return is_load && (rd != 5'd0) &&
           ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//   Bundle between the pipeline datapath and the hazard controller.
//   master : the pipeline side. It drives memory handshakes, register
//            indices and the branch redirect. It receives the load
//            enables, the PC load and the flush/bubble controls.
//   slave  : the hazard controller. state is exported for observability.
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  logic            imem_read;
  logic            imem_resp;
  logic            dmem_read;
  logic            dmem_write;
  logic            dmem_resp;
  logic            idex_is_load;
  logic [4:0]      idex_rd;
  logic [4:0]      ifid_rs1;
  logic [4:0]      ifid_rs2;
  logic            ifid_uses_rs1;
  logic            ifid_uses_rs2;
  logic            br_taken;
  pipe_ctrl_struct pipe_ctrl;
  logic            pc_ld;
  logic            ifid_flush;
  logic            idex_bubble;
  hazard_state_t   state;

  modport master (
    output imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
    output idex_is_load, idex_rd, ifid_rs1, ifid_rs2,
    output ifid_uses_rs1, ifid_uses_rs2, br_taken,
    input  pipe_ctrl, pc_ld, ifid_flush, idex_bubble, state
  );

  modport slave (
    input  imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
    input  idex_is_load, idex_rd, ifid_rs1, ifid_rs2,
    input  ifid_uses_rs1, ifid_uses_rs2, br_taken,
    output pipe_ctrl, pc_ld, ifid_flush, idex_bubble, state
  );

endinterface

// File: rtl/pipe_hazard_ctrl_perf_cnt.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_perf_cnt
//   RUN / MEM_STALL state tracking and the wrap-around performance counters.
//   Ports:
//     clk, rst   : clock, asynchronous active-low reset
//     cause      : hazard cause selected by the priority decode this cycle
//     state      : current FSM state (observability only)
//     stall_cnt  : cycles stalled by memory wait or load-use
//     flush_cnt  : taken-branch flushes
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl_perf_cnt
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  hazard_cause_t    cause,
  output hazard_state_t    state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hazard_state_t    state_q, state_d;
  logic [CNT_W-1:0] stall_q, flush_q;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      if ((cause == HZ_MEM) || (cause == HZ_LOADUSE))
        stall_q <= cnt_inc(stall_q);
      if (cause == HZ_BRANCH)
        flush_q <= cnt_inc(flush_q);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:       if (cause == HZ_MEM) state_d = MEM_STALL;
      MEM_STALL: if (cause != HZ_MEM) state_d = RUN;
      default:   state_d = RUN;
    endcase
  end

  assign state     = state_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Produces the pipeline load enables, the PC load and the IF/ID flush and
//   ID/EX bubble controls. Causes are resolved with this priority:
//   memory wait-state, then taken branch, then load-use.
//   Ports:
//     clk, rst  : clock, asynchronous active-low reset
//     hz        : pipe_hazard_ctrl_if.slave (requests in, controls out)
//     stall_cnt : cycles with a memory stall or load-use stall (wraps)
//     flush_cnt : taken-branch flush cycles (wraps)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_hazard_ctrl_if.slave    hz,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  // Sticky "response already seen" flags. A port whose response arrived
  // while the other port was still busy must not be treated as waiting again.
  logic i_done_q, d_done_q;
  logic i_done_d, d_done_d;

  logic i_busy, d_busy, mem_stall, lu;

  hazard_cause_t   cause;
  pipe_ctrl_struct ctrl;
  logic            pc_ld, ifid_flush, idex_bubble;

  assign i_busy    = hz.imem_read & ~hz.imem_resp & ~i_done_q;
  assign d_busy    = (hz.dmem_read | hz.dmem_write) & ~hz.dmem_resp & ~d_done_q;
  assign mem_stall = i_busy | d_busy;

  assign lu = load_use(hz.idex_is_load, hz.idex_rd, hz.ifid_rs1, hz.ifid_rs2,
                       hz.ifid_uses_rs1, hz.ifid_uses_rs2);

  // The clear condition takes priority over the set condition.
  always_comb begin
    i_done_d = i_done_q;
    d_done_d = d_done_q;
    if (!mem_stall) begin
      i_done_d = 1'b0;
      d_done_d = 1'b0;
    end else begin
      if (hz.imem_resp) i_done_d = 1'b1;
      if (hz.dmem_resp) d_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
    end else begin
      i_done_q <= i_done_d;
      d_done_q <= d_done_d;
    end
  end

  // Priority decode. While stalled on memory, br_taken and lu are dropped.
  // The frozen EX/ID stages present them again on the release cycle.
  always_comb begin
    cause       = HZ_NONE;
    ctrl        = ctrl_fill(1'b1);
    pc_ld       = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst) begin
      ctrl  = ctrl_fill(1'b0);
      pc_ld = 1'b0;
    end else if (mem_stall) begin
      cause = HZ_MEM;
      ctrl  = ctrl_fill(1'b0);
      pc_ld = 1'b0;
    end else if (hz.br_taken) begin
      cause       = HZ_BRANCH;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu) begin
      cause              = HZ_LOADUSE;
      pc_ld              = 1'b0;
      ctrl.ifid_pcreg_ld = 1'b0;
      ctrl.ifid_ireg_ld  = 1'b0;
      idex_bubble        = 1'b1;
    end
  end

  assign hz.pipe_ctrl   = ctrl;
  assign hz.pc_ld       = pc_ld;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_bubble = idex_bubble;

  pipe_hazard_ctrl_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk       (clk),
    .rst       (rst),
    .cause     (cause),
    .state     (hz.state),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed vectors for pipe_hazard_ctrl. Each step drives one cycle of
//   inputs and queues the hand-computed response for that cycle. A monitor
//   on the falling edge pops the queue and compares it with the DUT outputs.
//   Counters, state and i_done are the registered values seen during the
//   cycle, so they reflect only the earlier cycles.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int CNT_W = 32;

  // Expected output classes.
  localparam int K_ZERO = 0;  // reset or memory stall: everything frozen
  localparam int K_RUN  = 1;
  localparam int K_BR   = 2;
  localparam int K_LU   = 3;

  // Register-pattern selectors for the ID/EX and IF/ID fields.
  localparam int H_NONE = 0;
  localparam int H_LU   = 1;  // rd=5 matches rs2, uses_rs2=1
  localparam int H_RD0  = 2;  // load to x0 matched by rs1/rs2: no hazard
  localparam int H_NOUS = 3;  // rs1 matches rd but uses_rs1=0: no hazard

  typedef struct {
    string         name;
    int            kind;
    int            stall;
    int            flush;
    hazard_state_t st;
    logic          idone;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl_if hz_if ();

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .hz        (hz_if.slave),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic step(input string name, input logic r,
                      input logic ir, input logic irsp,
                      input logic dr, input logic dw, input logic drsp,
                      input logic br, input int hzp,
                      input int kind, input int stall, input int flush,
                      input hazard_state_t st, input logic idone);
    exp_t e;
    @(posedge clk);
    #1;
    rst                 = r;
    hz_if.imem_read     = ir;
    hz_if.imem_resp     = irsp;
    hz_if.dmem_read     = dr;
    hz_if.dmem_write    = dw;
    hz_if.dmem_resp     = drsp;
    hz_if.br_taken      = br;
    hz_if.idex_is_load  = 1'b0;
    hz_if.idex_rd       = 5'd0;
    hz_if.ifid_rs1      = 5'd0;
    hz_if.ifid_rs2      = 5'd0;
    hz_if.ifid_uses_rs1 = 1'b0;
    hz_if.ifid_uses_rs2 = 1'b0;
    case (hzp)
      H_LU: begin
        hz_if.idex_is_load = 1'b1; hz_if.idex_rd = 5'd5;
        hz_if.ifid_rs1 = 5'd3; hz_if.ifid_rs2 = 5'd5;
        hz_if.ifid_uses_rs1 = 1'b1; hz_if.ifid_uses_rs2 = 1'b1;
      end
      H_RD0: begin
        hz_if.idex_is_load = 1'b1; hz_if.idex_rd = 5'd0;
        hz_if.ifid_uses_rs1 = 1'b1; hz_if.ifid_uses_rs2 = 1'b1;
      end
      H_NOUS: begin
        hz_if.idex_is_load = 1'b1; hz_if.idex_rd = 5'd7;
        hz_if.ifid_rs1 = 5'd7; hz_if.ifid_rs2 = 5'd2;
        hz_if.ifid_uses_rs1 = 1'b0; hz_if.ifid_uses_rs2 = 1'b1;
      end
      default: ;
    endcase
    e.name  = name;
    e.kind  = kind;
    e.stall = stall;
    e.flush = flush;
    e.st    = st;
    e.idone = idone;
    q.push_back(e);
  endtask

  // Monitor: the controller presents a response every cycle.
  exp_t             m_e;
  logic [18:0]      m_ctrl;
  logic             m_pc, m_fl, m_bb;
  logic             m_ok;

  always @(negedge clk) begin
    if (q.size() != 0) begin
      m_e = q.pop_front();
      case (m_e.kind)
        K_RUN:   begin m_ctrl = 19'h7FFFF; m_pc = 1'b1; m_fl = 1'b0; m_bb = 1'b0; end
        K_BR:    begin m_ctrl = 19'h7FFFF; m_pc = 1'b1; m_fl = 1'b1; m_bb = 1'b1; end
        K_LU:    begin m_ctrl = 19'h1FFFF; m_pc = 1'b0; m_fl = 1'b0; m_bb = 1'b1; end
        default: begin m_ctrl = 19'h00000; m_pc = 1'b0; m_fl = 1'b0; m_bb = 1'b0; end
      endcase
      m_ok = (hz_if.pipe_ctrl === m_ctrl) && (hz_if.pc_ld === m_pc) &&
             (hz_if.ifid_flush === m_fl) && (hz_if.idex_bubble === m_bb) &&
             (stall_cnt === CNT_W'(m_e.stall)) && (flush_cnt === CNT_W'(m_e.flush)) &&
             (hz_if.state === m_e.st) && (dut.i_done_q === m_e.idone);
      checks++;
      if (m_ok) passed++;
      else
        $display("FAIL %s: got ctrl=%05h pc=%0b fl=%0b bb=%0b stall=%0d flush=%0d st=%0d idone=%0b, want ctrl=%05h pc=%0b fl=%0b bb=%0b stall=%0d flush=%0d st=%0d idone=%0b",
                 m_e.name, hz_if.pipe_ctrl, hz_if.pc_ld, hz_if.ifid_flush, hz_if.idex_bubble,
                 stall_cnt, flush_cnt, hz_if.state, dut.i_done_q,
                 m_ctrl, m_pc, m_fl, m_bb, m_e.stall, m_e.flush, m_e.st, m_e.idone);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    hz_if.imem_read = 1'b0; hz_if.imem_resp = 1'b0;
    hz_if.dmem_read = 1'b0; hz_if.dmem_write = 1'b0; hz_if.dmem_resp = 1'b0;
    hz_if.br_taken = 1'b0; hz_if.idex_is_load = 1'b0; hz_if.idex_rd = 5'd0;
    hz_if.ifid_rs1 = 5'd0; hz_if.ifid_rs2 = 5'd0;
    hz_if.ifid_uses_rs1 = 1'b0; hz_if.ifid_uses_rs2 = 1'b0;

    //    name            rst ir rsp dr dw drsp br hz      kind    stall flush state      idone
    step("reset",         0, 1, 1, 0, 0, 0, 0, H_NONE, K_ZERO,  0, 0, RUN,       1'b0);
    step("run0",          1, 1, 1, 0, 0, 0, 0, H_NONE, K_RUN,   0, 0, RUN,       1'b0);
    step("run1",          1, 1, 1, 0, 0, 0, 0, H_NONE, K_RUN,   0, 0, RUN,       1'b0);
    step("run2",          1, 1, 1, 0, 0, 0, 0, H_NONE, K_RUN,   0, 0, RUN,       1'b0);
    // Instruction fetch wait: three stalled cycles.
    step("iwait1",        1, 1, 0, 0, 0, 0, 0, H_NONE, K_ZERO,  0, 0, RUN,       1'b0);
    step("iwait2",        1, 1, 0, 0, 0, 0, 0, H_NONE, K_ZERO,  1, 0, MEM_STALL, 1'b0);
    step("iwait3",        1, 1, 0, 0, 0, 0, 0, H_NONE, K_ZERO,  2, 0, MEM_STALL, 1'b0);
    step("iresp",         1, 1, 1, 0, 0, 0, 0, H_NONE, K_RUN,   3, 0, MEM_STALL, 1'b0);
    step("iback_run",     1, 1, 1, 0, 0, 0, 0, H_NONE, K_RUN,   3, 0, RUN,       1'b0);
    // Both ports busy. The I response arrives first and is held in i_done.
    step("both0",         1, 1, 0, 1, 0, 0, 0, H_NONE, K_ZERO,  3, 0, RUN,       1'b0);
    step("both1_iresp",   1, 1, 1, 1, 0, 0, 0, H_NONE, K_ZERO,  4, 0, MEM_STALL, 1'b0);
    step("both2_idone",   1, 1, 0, 1, 0, 0, 0, H_NONE, K_ZERO,  5, 0, MEM_STALL, 1'b1);
    step("both3_idone",   1, 1, 0, 1, 0, 0, 0, H_NONE, K_ZERO,  6, 0, MEM_STALL, 1'b1);
    step("both4_dresp",   1, 1, 0, 1, 0, 1, 0, H_NONE, K_RUN,   7, 0, MEM_STALL, 1'b1);
    step("both5_clear",   1, 1, 1, 0, 0, 0, 0, H_NONE, K_RUN,   7, 0, RUN,       1'b0);
    // Load-use hazard and the patterns that must not be treated as one.
    step("loaduse",       1, 1, 1, 0, 0, 0, 0, H_LU,   K_LU,    7, 0, RUN,       1'b0);
    step("after_lu",      1, 1, 1, 0, 0, 0, 0, H_NONE, K_RUN,   8, 0, RUN,       1'b0);
    step("lu_rd0",        1, 1, 1, 0, 0, 0, 0, H_RD0,  K_RUN,   8, 0, RUN,       1'b0);
    step("lu_unused_rs",  1, 1, 1, 0, 0, 0, 0, H_NOUS, K_RUN,   8, 0, RUN,       1'b0);
    // A branch in the same cycle overrides load-use.
    step("lu_and_br",     1, 1, 1, 0, 0, 0, 1, H_LU,   K_BR,    8, 0, RUN,       1'b0);
    step("after_br",      1, 1, 1, 0, 0, 0, 0, H_NONE, K_RUN,   8, 1, RUN,       1'b0);
    // A branch during a D-side stall flushes only on the response cycle.
    step("br_dstall1",    1, 1, 1, 1, 0, 0, 1, H_NONE, K_ZERO,  8, 1, RUN,       1'b0);
    step("br_dstall2",    1, 1, 0, 1, 0, 0, 1, H_NONE, K_ZERO,  9, 1, MEM_STALL, 1'b1);
    step("br_dresp",      1, 1, 0, 1, 0, 1, 1, H_NONE, K_BR,   10, 1, MEM_STALL, 1'b1);
    step("br_after",      1, 1, 1, 0, 0, 0, 0, H_NONE, K_RUN,  10, 2, RUN,       1'b0);
    // Reset asserted in the middle of a stall.
    step("pre_rst1",      1, 1, 0, 1, 0, 0, 0, H_NONE, K_ZERO, 10, 2, RUN,       1'b0);
    step("pre_rst2",      1, 1, 0, 1, 0, 0, 0, H_NONE, K_ZERO, 11, 2, MEM_STALL, 1'b0);
    step("rst_midstall",  0, 1, 0, 1, 0, 0, 0, H_NONE, K_ZERO,  0, 0, RUN,       1'b0);
    step("post_rst",      1, 1, 1, 0, 0, 0, 0, H_NONE, K_RUN,   0, 0, RUN,       1'b0);
    // Both responses in the same cycle, then a store wait.
    step("both_resp",     1, 1, 1, 1, 0, 1, 0, H_NONE, K_RUN,   0, 0, RUN,       1'b0);
    step("store_wait",    1, 1, 1, 0, 1, 0, 0, H_NONE, K_ZERO,  0, 0, RUN,       1'b0);
    step("store_resp",    1, 1, 1, 0, 1, 1, 0, H_NONE, K_RUN,   1, 0, MEM_STALL, 1'b1);
    step("store_after",   1, 1, 1, 0, 0, 0, 0, H_NONE, K_RUN,   1, 0, RUN,       1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: got %0d queued responses, want 0", q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Produces the per-stage pipeline-register load enables (pipe_ctrl_struct), the PC load and the IF/ID and ID/EX bubble/flush controls for the 5-stage RV32I pipeline.
- Combines three causes: I/D memory wait-states, load-use hazards and taken-branch redirects.
- Holds sticky per-port response flags so that a response arriving while the other port still stalls is not lost.
- Counts stall and flush events for performance analysis.

Parameters:
- CNT_W, 32, width of the performance counters (wrap-around, no saturation)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- imem_read  in  1  fetch request outstanding to I-cache
- imem_resp  in  1  I-cache response, single-cycle pulse
- dmem_read  in  1  MEM-stage load request
- dmem_write  in  1  MEM-stage store request
- dmem_resp  in  1  D-cache response, single-cycle pulse
- idex_is_load  in  1  instruction in ID/EX is a load (opcode op_load)
- idex_rd  in  5  rd of the ID/EX instruction
- ifid_rs1  in  5  rs1 of the IF/ID instruction
- ifid_rs2  in  5  rs2 of the IF/ID instruction
- ifid_uses_rs1  in  1  IF/ID instruction reads rs1
- ifid_uses_rs2  in  1  IF/ID instruction reads rs2
- br_taken  in  1  EX-stage branch/jump redirect
- pipe_ctrl  out  19  pipe_ctrl_struct load enables
- pc_ld  out  1  PC register load
- ifid_flush  out  1  IF/ID register loads a NOP
- idex_bubble  out  1  ID/EX register loads a NOP
- stall_cnt  out  CNT_W  cycles with the pipeline frozen
- flush_cnt  out  CNT_W  number of taken-branch flushes

Behaviour:
- Reset (rst low, asynchronous):
  - state = RUN; i_done = d_done = 0; both counters = 0.
  - While rst is low, all combinational outputs are forced to 0.
- Busy terms:
  - i_busy = imem_read & ~imem_resp & ~i_done
  - d_busy = (dmem_read | dmem_write) & ~dmem_resp & ~d_done
  - mem_stall = i_busy | d_busy
- Sticky flags:
  - i_done is set when imem_resp & mem_stall (the other port is still waiting).
  - d_done is set the same way from dmem_resp.
  - Both flags clear on any cycle with mem_stall = 0.
  - If the set and clear conditions coincide, the clear wins.
- FSM states RUN and MEM_STALL:
  - RUN -> MEM_STALL when mem_stall.
  - MEM_STALL -> RUN when !mem_stall.
  - State is for the counters and observability only; outputs are decoded from the current-cycle terms below.
- Load-use hazard:
  - lu = idex_is_load & (idex_rd != 0) & ((ifid_uses_rs1 & ifid_rs1 == idex_rd) | (ifid_uses_rs2 & ifid_rs2 == idex_rd))
- Output priority, all combinational, zero latency:
  1. mem_stall:
     - every pipe_ctrl bit = 0, pc_ld = 0, ifid_flush = 0, idex_bubble = 0.
     - br_taken and lu are ignored; the frozen EX/ID stages re-present them next cycle.
  2. br_taken:
     - every pipe_ctrl bit = 1, pc_ld = 1, ifid_flush = 1, idex_bubble = 1.
     - lu is suppressed because the instruction that caused it is flushed.
  3. lu:
     - pc_ld = 0; ifid_ireg_ld = ifid_pcreg_ld = 0.
     - all idex/exmem/memwb loads = 1; idex_bubble = 1.
  4. Otherwise: all loads = 1, pc_ld = 1, flushes = 0.
- Counters:
  - stall_cnt increments on every cycle with mem_stall, and on every cycle where lu is the selected cause.
  - flush_cnt increments on every cycle where br_taken is the selected cause (priority 2).
  - Both wrap at 2^CNT_W.
- Responses arriving together: imem_resp and dmem_resp in the same cycle with no other pending request give mem_stall = 0; the pipeline advances that cycle.
- Reset mid-stall: all state clears immediately; any pending memory request is re-issued by its requester after reset.

Decomposition:
- pipe_ctrl_struct stays in the shared types package.
- Add to the same package:
  - hazard_state_t enum {RUN, MEM_STALL}
  - hazard_cause_t enum {HZ_NONE, HZ_MEM, HZ_BRANCH, HZ_LOADUSE}
- A hazard_perf_cnt sub-module (state + counters, input hazard_cause_t) is natural.
- The priority decode stays in the top block.

Test Plan:
- No hazards, imem_read=1 with imem_resp every cycle -> pipe_ctrl = 19'h7FFFF, pc_ld = 1, stall_cnt stays 0.
- imem_read=1 with imem_resp delayed 3 cycles -> 3 cycles with pipe_ctrl = 0 and pc_ld = 0; stall_cnt = 3; state returns to RUN.
- dmem_read=1 and imem_read=1; imem_resp at cycle 1, dmem_resp at cycle 4:
  - i_done is set at cycle 1; stall persists through cycle 3.
  - The pipeline advances at cycle 4; i_done clears.
- idex_is_load, idex_rd=5, ifid_rs2=5, ifid_uses_rs2=1 -> one cycle with pc_ld = 0, ifid loads = 0, idex_bubble = 1; stall_cnt += 1.
- Repeat the load-use case with br_taken=1 in the same cycle -> ifid_flush = 1, idex_bubble = 1, pc_ld = 1, flush_cnt = 1, stall_cnt unchanged.
- br_taken=1 during a dmem stall, dmem_resp two cycles later -> no flush while stalled; flush asserted exactly on the response cycle. Then pull rst low mid-stall -> all outputs 0 immediately, counters 0.
